// File: rtl/vend_pkg.sv
// Shared state, coin encoding and credit types for the vending sequencer.
// Coin codes are reused for the change-return path.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    typedef logic [6:0] credit_t;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_25  = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam credit_t COIN_VALUE [4] = '{7'd5, 7'd10, 7'd25, 7'd0};

    function automatic credit_t coin_value(input logic [1:0] code);
        return COIN_VALUE[code];
    endfunction

    // Credit is always a multiple of 5, so a non-zero amount always fits a 5.
    function automatic logic [1:0] largest_coin(input credit_t amount);
        if (amount >= 7'd25) begin
            return COIN_25;
        end else if (amount >= 7'd10) begin
            return COIN_10;
        end else begin
            return COIN_5;
        end
    endfunction

endpackage

// File: rtl/vend_stock.sv
// Per-item stock counter: loads INIT on reset, decrements on strobe, never wraps.
// Latency: count updates on the strobe edge; zero flag is combinational from the count.
// Backpressure: none; a strobe at zero is ignored.
module vend_stock #(
    parameter logic [3:0] INIT = 4'd0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dec,
    output logic zero
);

    logic [3:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= INIT;
        end else if (dec && (count_q != 4'd0)) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign zero = (count_q == 4'd0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: coin credit, fixed-priority item grant, vend pulse, optional change return (VEND_CHANGE_EN).
// Latency: Buy at edge N -> Vending in cycle N+1, credit/stock deducted leaving VEND, first change coin right after.
// Backpressure: none; coins outside IDLE are rejected and Buy outside IDLE is dropped, not queued.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int         COST0      = 5,
    parameter int         COST1      = 10,
    parameter int         COST2      = 15,
    parameter int         COST3      = 30,
    parameter logic [3:0] STOCK0     = 4'd6,
    parameter logic [3:0] STOCK1     = 4'd2,
    parameter logic [3:0] STOCK2     = 4'd1,
    parameter logic [3:0] STOCK3     = 4'd1,
    parameter int         CREDIT_MAX = 100
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       CoinValid,
    input  logic [1:0] CoinVal,
    input  logic [3:0] Buy,
    input  logic       Refund,
    output logic [6:0] Credit,
    output logic [3:0] Vending,
    output logic       Deny,
    output logic       CoinReject,
    output logic [3:0] SoldOut,
    output logic       Busy,
    output logic       ChangeCoin,
    output logic [1:0] ChangeVal
);

    localparam logic [7:0] CREDIT_LIM = 8'(CREDIT_MAX);
    localparam logic [3:0] STOCK_INIT [4] = '{STOCK0, STOCK1, STOCK2, STOCK3};

    function automatic credit_t cost_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return credit_t'(COST0);
            2'd1:    return credit_t'(COST1);
            2'd2:    return credit_t'(COST2);
            default: return credit_t'(COST3);
        endcase
    endfunction

    state_t     state_q, state_d;
    credit_t    credit_q, credit_d;
    logic [1:0] grant_q, grant_d;
    logic [3:0] vend_q, vend_d;
    logic       deny_q, deny_d;
    logic       rej_q, rej_d;
    logic       chg_q, chg_d;
    logic [1:0] chgval_q, chgval_d;

    logic [3:0] stock_dec;
    logic [3:0] soldout;
    logic [7:0] coin_sum;
    logic       coin_ok;
    logic [1:0] req_idx;
    logic       req_elig;
    credit_t    post_vend;

`ifndef VEND_CHANGE_EN
    logic unused_refund;
    assign unused_refund = Refund;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_stock
        vend_stock #(.INIT(STOCK_INIT[i])) u_stock (
            .clk     (Clk),
            .reset_n (Reset_n),
            .dec     (stock_dec[i]),
            .zero    (soldout[i])
        );
    end

    // Lowest asserted button wins.
    always_comb begin
        req_idx = 2'd3;
        if (Buy[0]) begin
            req_idx = 2'd0;
        end else if (Buy[1]) begin
            req_idx = 2'd1;
        end else if (Buy[2]) begin
            req_idx = 2'd2;
        end
    end

    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value(CoinVal)};
    assign coin_ok   = CoinValid && (CoinVal != COIN_BAD) && (coin_sum <= CREDIT_LIM);
    assign req_elig  = (credit_q >= cost_of(req_idx)) && !soldout[req_idx];
    assign post_vend = credit_q - cost_of(grant_q);

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        grant_d   = grant_q;
        vend_d    = 4'b0000;
        deny_d    = 1'b0;
        rej_d     = CoinValid && !((state_q == IDLE) && coin_ok);
        chg_d     = 1'b0;
        chgval_d  = 2'b00;
        stock_dec = 4'b0000;

        case (state_q)
            IDLE: begin
                if (coin_ok) begin
                    credit_d = coin_sum[6:0];
                end
                // Eligibility uses the credit held before any same-cycle coin.
                if (|Buy) begin
                    if (req_elig) begin
                        grant_d = req_idx;
                        vend_d  = 4'b0001 << req_idx;
                        state_d = VEND;
                    end else begin
                        deny_d = 1'b1;
                    end
                end
`ifdef VEND_CHANGE_EN
                else if (Refund && (credit_q != 7'd0)) begin
                    chg_d    = 1'b1;
                    chgval_d = largest_coin(credit_d);
                    credit_d = credit_d - coin_value(chgval_d);
                    state_d  = CHANGE;
                end
`endif
            end

            VEND: begin
                stock_dec[grant_q] = 1'b1;
                credit_d           = post_vend;
                state_d            = IDLE;
`ifdef VEND_CHANGE_EN
                // First change coin leaves on the same edge as the deduction.
                if (post_vend != 7'd0) begin
                    chg_d    = 1'b1;
                    chgval_d = largest_coin(post_vend);
                    credit_d = post_vend - coin_value(chgval_d);
                    state_d  = CHANGE;
                end
`endif
            end

            CHANGE: begin
`ifdef VEND_CHANGE_EN
                if (credit_q != 7'd0) begin
                    chg_d    = 1'b1;
                    chgval_d = largest_coin(credit_q);
                    credit_d = credit_q - coin_value(chgval_d);
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            credit_q <= 7'd0;
            grant_q  <= 2'd0;
            vend_q   <= 4'b0000;
            deny_q   <= 1'b0;
            rej_q    <= 1'b0;
            chg_q    <= 1'b0;
            chgval_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            vend_q   <= vend_d;
            deny_q   <= deny_d;
            rej_q    <= rej_d;
            chg_q    <= chg_d;
            chgval_q <= chgval_d;
        end
    end

    assign Credit     = credit_q;
    assign Vending    = vend_q;
    assign Deny       = deny_q;
    assign CoinReject = rej_q;
    assign SoldOut    = soldout;
    assign Busy       = (state_q != IDLE);
    assign ChangeCoin = chg_q;
    assign ChangeVal  = chgval_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed vector bench for vend_sequencer; follows VEND_CHANGE_EN if defined for the build.
// Each table row drives one cycle of inputs and checks the registered outputs just after the edge.
module tb_vend_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       CoinValid;
    logic [1:0] CoinVal;
    logic [3:0] Buy;
    logic       Refund;
    logic [6:0] Credit;
    logic [3:0] Vending;
    logic       Deny;
    logic       CoinReject;
    logic [3:0] SoldOut;
    logic       Busy;
    logic       ChangeCoin;
    logic [1:0] ChangeVal;

    int vectors     = 0;
    int miscompares = 0;

    vend_sequencer dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .CoinValid  (CoinValid),
        .CoinVal    (CoinVal),
        .Buy        (Buy),
        .Refund     (Refund),
        .Credit     (Credit),
        .Vending    (Vending),
        .Deny       (Deny),
        .CoinReject (CoinReject),
        .SoldOut    (SoldOut),
        .Busy       (Busy),
        .ChangeCoin (ChangeCoin),
        .ChangeVal  (ChangeVal)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       cv;
        logic [1:0] val;
        logic [3:0] buy;
        logic       rf;
        logic [6:0] credit;
        logic [3:0] vend;
        logic       deny;
        logic       rej;
        logic       busy;
        logic [3:0] so;
        logic       chg;
        logic [1:0] cval;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cv, input logic [1:0] val, input logic [3:0] buy,
                                input logic rf, input logic [6:0] credit, input logic [3:0] vend,
                                input logic deny, input logic rej, input logic busy,
                                input logic [3:0] so, input logic chg, input logic [1:0] cval);
        vec_t v;
        v.cv = cv; v.val = val; v.buy = buy; v.rf = rf;
        v.credit = credit; v.vend = vend; v.deny = deny; v.rej = rej;
        v.busy = busy; v.so = so; v.chg = chg; v.cval = cval;
        return v;
    endfunction

    task automatic check(input string tag, input vec_t e);
        vectors++;
        if (Credit !== e.credit || Vending !== e.vend || Deny !== e.deny || CoinReject !== e.rej ||
            Busy !== e.busy || SoldOut !== e.so || ChangeCoin !== e.chg || ChangeVal !== e.cval) begin
            miscompares++;
            $display("FAIL %s: got credit=%0d vend=%b deny=%b rej=%b busy=%b soldout=%b chg=%b chgval=%b; want credit=%0d vend=%b deny=%b rej=%b busy=%b soldout=%b chg=%b chgval=%b",
                     tag, Credit, Vending, Deny, CoinReject, Busy, SoldOut, ChangeCoin, ChangeVal,
                     e.credit, e.vend, e.deny, e.rej, e.busy, e.so, e.chg, e.cval);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge Clk);
        CoinValid = v.cv;
        CoinVal   = v.val;
        Buy       = v.buy;
        Refund    = v.rf;
        @(posedge Clk);
        #1;
        check(tag, v);
    endtask

    // Asserts reset mid-cycle and checks that everything clears at once.
    task automatic async_reset(input string tag);
        CoinValid = 1'b0;
        CoinVal   = 2'b00;
        Buy       = 4'b0000;
        Refund    = 1'b0;
        Reset_n   = 1'b0;
        #1;
        check(tag, mk(0, 2'b00, 4'b0000, 0, 7'd0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n   = 1'b0;
        CoinValid = 1'b0;
        CoinVal   = 2'b00;
        Buy       = 4'b0000;
        Refund    = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset", mk(0, 2'b00, 4'b0000, 0, 7'd0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        Reset_n = 1'b1;

        // Reset while VEND is active: no vend completes afterwards.
        apply("midvend_coin", mk(1, 2'b00, 4'b0000, 0, 7'd5, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        apply("midvend_buy",  mk(0, 2'b00, 4'b0001, 0, 7'd5, 4'b0001, 0, 0, 1, 4'b0000, 0, 2'b00));
        async_reset("midvend_rst");
        apply("midvend_after", mk(0, 2'b00, 4'b0000, 0, 7'd0, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));

`ifdef VEND_CHANGE_EN
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd10, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd20, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0001, 0, 7'd20, 4'b0001, 0, 0, 1, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd5,  4'b0000, 0, 0, 1, 4'b0000, 1, 2'b01));
        tbl.push_back(mk(1, 2'b00, 4'b0000, 0, 7'd0,  4'b0000, 0, 1, 1, 4'b0000, 1, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd0,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(1, 2'b10, 4'b0000, 0, 7'd25, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd35, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd45, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 1, 7'd20, 4'b0000, 0, 0, 1, 4'b0000, 1, 2'b10));
        tbl.push_back(mk(0, 2'b00, 4'b0001, 0, 7'd10, 4'b0000, 0, 0, 1, 4'b0000, 1, 2'b01));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd0,  4'b0000, 0, 0, 1, 4'b0000, 1, 2'b01));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd0,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 1, 7'd0,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(1, 2'b00, 4'b0000, 0, 7'd5,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0001, 0, 7'd5,  4'b0001, 0, 0, 1, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd0,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(1, 2'b10, 4'b0010, 1, 7'd25, 4'b0000, 1, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 1, 7'd0,  4'b0000, 0, 0, 1, 4'b0000, 1, 2'b10));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd0,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
`else
        tbl.push_back(mk(1, 2'b10, 4'b0000, 0, 7'd25,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(1, 2'b00, 4'b0000, 0, 7'd30,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b1010, 0, 7'd30,  4'b0010, 0, 0, 1, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd20,  4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0010, 0, 7'd20,  4'b0010, 0, 0, 1, 4'b0000, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd10,  4'b0000, 0, 0, 0, 4'b0010, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0010, 0, 7'd10,  4'b0000, 1, 0, 0, 4'b0010, 0, 2'b00));
        tbl.push_back(mk(1, 2'b10, 4'b0100, 0, 7'd35,  4'b0000, 1, 0, 0, 4'b0010, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0100, 0, 7'd35,  4'b0100, 0, 0, 1, 4'b0010, 0, 2'b00));
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd20,  4'b0000, 0, 1, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0100, 0, 7'd20,  4'b0000, 1, 0, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b11, 4'b0000, 0, 7'd20,  4'b0000, 0, 1, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b10, 4'b0000, 0, 7'd45,  4'b0000, 0, 0, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b10, 4'b0000, 0, 7'd70,  4'b0000, 0, 0, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd80,  4'b0000, 0, 0, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd90,  4'b0000, 0, 0, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b10, 4'b0000, 0, 7'd90,  4'b0000, 0, 1, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b01, 4'b0000, 0, 7'd100, 4'b0000, 0, 0, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(1, 2'b00, 4'b0000, 0, 7'd100, 4'b0000, 0, 1, 0, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b1000, 0, 7'd100, 4'b1000, 0, 0, 1, 4'b0110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b1000, 0, 7'd70,  4'b0000, 0, 0, 0, 4'b1110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b1000, 0, 7'd70,  4'b0000, 1, 0, 0, 4'b1110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0001, 0, 7'd70,  4'b0001, 0, 0, 1, 4'b1110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0001, 0, 7'd65,  4'b0000, 0, 0, 0, 4'b1110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0001, 0, 7'd65,  4'b0001, 0, 0, 1, 4'b1110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 0, 7'd60,  4'b0000, 0, 0, 0, 4'b1110, 0, 2'b00));
        tbl.push_back(mk(0, 2'b00, 4'b0000, 1, 7'd60,  4'b0000, 0, 0, 0, 4'b1110, 0, 2'b00));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

`ifdef VEND_CHANGE_EN
        // Reset while returning change with 20 still owed.
        apply("midchg_c25", mk(1, 2'b10, 4'b0000, 0, 7'd25, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        apply("midchg_c10", mk(1, 2'b01, 4'b0000, 0, 7'd35, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        apply("midchg_c10b", mk(1, 2'b01, 4'b0000, 0, 7'd45, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        apply("midchg_ref", mk(0, 2'b00, 4'b0000, 1, 7'd20, 4'b0000, 0, 0, 1, 4'b0000, 1, 2'b10));
        async_reset("midchg_rst");
`endif

        // Stocks must reload: item 2 is sellable again after reset.
        async_reset("final_rst");
        apply("reload_coin", mk(1, 2'b10, 4'b0000, 0, 7'd25, 4'b0000, 0, 0, 0, 4'b0000, 0, 2'b00));
        apply("reload_buy",  mk(0, 2'b00, 4'b0100, 0, 7'd25, 4'b0100, 0, 0, 1, 4'b0000, 0, 2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Synchronous controller for the vending datapath. It accepts coin inserts into a credit register and arbitrates simultaneous item requests with a fixed priority. For each granted request it checks credit and stock, issues a one-cycle vend pulse, deducts the item cost and decrements that item's stock. It can optionally return change coin-by-coin. It replaces the edge-triggered buy/stock logic with a single-clock sequencer that sits between the front-panel inputs and the dispenser/coin-return actuators.

## Interface
Parameters:
- COST0, 5: price of item 0 (multiple of 5)
- COST1, 10: price of item 1
- COST2, 15: price of item 2
- COST3, 30: price of item 3
- STOCK0..STOCK3, 6/2/1/1: stock loaded at reset (4-bit)
- CREDIT_MAX, 100: credit ceiling (≤127, multiple of 5)

Ports:
- Clk, in, 1: clock, all state on rising edge
- Reset_n, in, 1: asynchronous, active-low reset
- CoinValid, in, 1: coin present this cycle
- CoinVal, in, 2: 00=5, 01=10, 10=25, 11=illegal (rejected)
- Buy, in, 4: item request buttons, level, any combination
- Refund, in, 1: return-credit request
- Credit, out, 7: current credit
- Vending, out, 4: one-hot dispense pulse, one cycle
- Deny, out, 1: request refused (credit or stock), one-cycle pulse
- CoinReject, out, 1: coin refused, one-cycle pulse
- SoldOut, out, 4: stock of item i is zero
- Busy, out, 1: state ≠ IDLE
- ChangeCoin, out, 1: one coin returned this cycle
- ChangeVal, out, 2: value of returned coin, same encoding as CoinVal

## Operation
- States: IDLE, VEND, CHANGE.
- **IDLE, coins**:
  - A legal coin is accepted when Credit + value ≤ CREDIT_MAX. Credit updates on that edge.
  - Otherwise the coin is refused and CoinReject pulses next cycle.
- **IDLE, Buy**:
  - The lowest asserted index wins; other bits are ignored that cycle.
  - Eligible means Credit ≥ COSTi and stock i ≠ 0, judged on Credit before any same-cycle coin.
  - Eligible: latch grant index, go to VEND.
  - Not eligible: Deny pulses next cycle and the state stays IDLE.
- **VEND**:
  - Vending[grant]=1 for exactly one cycle.
  - On exit: Credit −= COSTi and stock i −= 1.
  - Next state is CHANGE if change is enabled and the post-vend Credit > 0; otherwise IDLE.
- **IDLE, Refund**: with Credit > 0 and no Buy asserted, go to CHANGE. Buy has priority over Refund.
- **CHANGE**:
  - Each cycle, emit the largest coin ≤ Credit (25, then 10, then 5) and subtract it.
  - Return to IDLE in the cycle after Credit reaches 0.
- **Coins outside IDLE**: always refused (CoinReject).
- **Buy outside IDLE**: ignored; it is not queued.
- **Arithmetic and sticky state**:
  - Credit arithmetic is 7-bit unsigned and can never underflow, because eligibility is checked first.
  - Stock never wraps below 0; SoldOut is sticky until reset.
- **Reset** (asynchronous, any state, including mid-VEND or mid-CHANGE):
  - State goes to IDLE, Credit=0, stocks reload from parameters.
  - All pulse outputs, SoldOut and ChangeVal go to 0.
  - No partial vend or change completes.

## Timing
- Registered outputs: Vending, Deny, CoinReject, ChangeCoin and ChangeVal.
- Combinational from state only: Busy and SoldOut.
- Buy sampled at edge N: Vending at cycle N+1; Credit reduced at edge N+2.
- First change coin appears at cycle N+2.
- A vend transaction occupies 2 cycles plus one cycle per change coin.
- Coin sampled at edge N: Credit valid at N+1.
- Buy held high re-arms only after returning to IDLE. A held button vends again once per pass through IDLE while still eligible.

## Configuration
- VEND_CHANGE_EN defined:
  - CHANGE state exists.
  - Leftover credit is returned after each vend.
  - Refund is honoured.
- VEND_CHANGE_EN undefined:
  - No CHANGE state; VEND always returns to IDLE.
  - Leftover credit carries over for further purchases.
  - Refund is ignored.
  - ChangeCoin and ChangeVal are tied to 0.

## Structure
- Package vend_pkg holds:
  - state_t enum (IDLE, VEND, CHANGE)
  - coin encoding constants and the 7-bit credit_t typedef
  - coin value table (5/10/25)
- Sub-module vend_stock: one instance per item. It contains a 4-bit down-counter with parameter load value, a decrement strobe and a zero flag (SoldOut).

## Test plan
- Reset, insert 10+10 then Buy=0001 (macro on) → Vending=0001 one cycle, then ChangeCoin 10, then 5, then Credit=0, IDLE.
- Credit=30, Buy=1010 same cycle → item 1 wins; Vending=0010; Credit 20 (macro off), stock1 = 1.
- Item 2 bought once (stock 1→0) → SoldOut[2]=1; next Buy=0100 with Credit=50 → Deny, Credit unchanged.
- Credit=90, coin 25 → CoinReject, Credit 90; coin during VEND → CoinReject; CoinVal=11 → CoinReject.
- Credit=45, Refund (macro on) → coins 25, 10, 10 over three cycles, Busy high throughout.
- Reset_n low during CHANGE with Credit=20 → immediate Credit=0, IDLE, SoldOut=0000, stocks 6/2/1/1.
